// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD frame, blanking gap per digit slot.
// Optional LEADING_ZERO_BLANK_EN suppresses leading-zero digits above digit 0.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_full_q, pend_full_d;
    logic                    started_q;
    logic                    boundary;
    logic                    show;
    logic [NUM_DIGITS-1:0]   an_n_d;
    logic [3:0]              bcd_d;
    logic                    tick_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    zero_run;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        boundary    = 1'b0;

        // The first cycle after reset release holds slot position 0 so the tick lands on it.
        if (started_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = ST_BLANK;
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    boundary = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                end
            end
        end

        if (boundary && pend_full_q) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end
        if (value_valid && value_ready) begin
            pending_d   = value_in;
            pend_full_d = 1'b1;
        end

        show = (state_d == ST_SHOW);
`ifdef LEADING_ZERO_BLANK_EN
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (active_d[4*k +: 4] == 4'h0);
            if ((int'(idx_d) == k) && zero_run) begin
                show = 1'b0;
            end
        end
`endif

        an_n_d = '1;
        bcd_d  = 4'hF;
        if (show) begin
            an_n_d[idx_d] = 1'b0;
            bcd_d         = active_d[4*idx_d +: 4];
        end
        tick_d = !started_q || boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            started_q   <= 1'b0;
            an_n        <= '1;
            bcd_out     <= 4'hF;
            value_ready <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            started_q   <= 1'b1;
            an_n        <= an_n_d;
            bcd_out     <= bcd_d;
            value_ready <= !pend_full_d;
            frame_tick  <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame/slot arithmetic model of the display.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value_in = '0;
    logic          value_valid = 1'b0;
    logic          value_ready;
    logic [3:0]    bcd_out;
    logic [ND-1:0] an_n;
    logic          frame_tick;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .bcd_out     (bcd_out),
        .an_n        (an_n),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_active;
    logic [15:0] m_pend;
    bit          m_full;
    int          t;
    logic [15:0] offer_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    task automatic model_reset();
        m_active = '0;
        m_pend   = '0;
        m_full   = 1'b0;
        t        = 0;
    endtask

    // Expected outputs for the current cycle from frame position and the shown frame.
    task automatic check_cycle();
        int          pos, dig, slot;
        bit          lit;
        logic [3:0]  exp_an, exp_bcd;
        logic [15:0] above;
        pos   = t % FRAME;
        dig   = pos / RD;
        slot  = pos % RD;
        above = m_active >> (4 * dig);
        lit   = (slot >= BC);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && above == 16'h0) lit = 1'b0;
`endif
        exp_an  = lit ? ~(4'b0001 << dig) : 4'hF;
        exp_bcd = lit ? above[3:0] : 4'hF;
        check("an_n", 32'(an_n), 32'(exp_an));
        check("bcd_out", 32'(bcd_out), 32'(exp_bcd));
        check("frame_tick", 32'(frame_tick), 32'(pos == 0));
        check("value_ready", 32'(value_ready), 32'(!m_full));
        check("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
    endtask

    // Called at a negedge; leaves the bench at the negedge of the first frame_tick cycle.
    task automatic sync_frame();
        int waited = 0;
        while (frame_tick !== 1'b1 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check("sync_tick", 32'(frame_tick), 32'd1);
        t = 0;
    endtask

    // mode 0: idle, 1: random offers, 2: hold queue head until accepted
    task automatic run(input int n, input int mode);
        bit ready_before;
        for (int i = 0; i < n; i++) begin
            check_cycle();
            case (mode)
                1: begin
                    value_valid = ($urandom_range(0, 5) == 0);
                    value_in    = 16'($urandom);
                end
                2: begin
                    value_valid = (offer_q.size() != 0);
                    value_in    = (offer_q.size() != 0) ? offer_q[0] : 16'h0;
                end
                default: value_valid = 1'b0;
            endcase
            @(posedge clk);
            ready_before = !m_full;
            if ((t % FRAME) == FRAME - 1 && m_full) begin
                m_active = m_pend;
                m_full   = 1'b0;
            end
            if (value_valid && ready_before) begin
                m_pend = value_in;
                m_full = 1'b1;
                if (mode == 2) void'(offer_q.pop_front());
            end
            t++;
            @(negedge clk);
        end
        value_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an_n", 32'(an_n), 32'hF);
        check("rst_bcd", 32'(bcd_out), 32'hF);
        check("rst_ready", 32'(value_ready), 32'd1);
        check("rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        sync_frame();

        run(FRAME + 13, 0);
        offer_q.push_back(16'h1234);
        run(3 * FRAME, 2);
        offer_q.push_back(16'h5678);
        offer_q.push_back(16'h9999);
        run(4 * FRAME, 2);
        run(6 * FRAME, 1);

        // Get pending full while a digit is lit, then reset asynchronously.
        offer_q.push_back(16'h4321);
        for (int k = 0; k < 100; k++) begin
            if (m_full && (t % RD) >= BC + 1) break;
            run(1, 2);
        end
        check("pre_reset_full", 32'(m_full), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_an_n", 32'(an_n), 32'hF);
        check("async_bcd", 32'(bcd_out), 32'hF);
        check("async_ready", 32'(value_ready), 32'd1);
        check("async_tick", 32'(frame_tick), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        offer_q.delete();
        sync_frame();
        run(2 * FRAME, 0);

        offer_q.push_back(16'h0050);
        offer_q.push_back(16'h0000);
        offer_q.push_back(16'h0A0F);
        offer_q.push_back(16'hF000);
        run(6 * FRAME, 2);
        run(4 * FRAME, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
